dc_dac_spi_writer: RTL

- Sits directly downstream of the DC frame dispatcher.
- On a frame-valid pulse, latches the 62-word DC frame and the 5-bit channel select.
- Serialises payload words 1..FRAME_WORDS-1 over SPI to the DAC selected by a one-hot active-low chip select.
- Reports busy, done, dropped-frame and bad-channel status.

---
 rtl/dc_dac_spi_writer.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dc_dac_spi_writer.sv
// dc_dac_spi_writer
//
// Takes a DC frame from the frame dispatcher and writes its payload words
// (1..FRAME_WORDS-1) to one DAC over SPI mode 0, MSB first. Word 0 is the
// frame header and is never shifted out.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous, active-low reset
//   i_frame        FRAME_WORDS x 32 frame, word k at [k*32 +: 32]
//   i_channel_sel  target DAC index
//   i_frame_valid  one-cycle frame strobe
//   o_busy         transfer in progress
//   o_done         one-cycle pulse when the last word has been shifted
//   o_frame_drop   one-cycle pulse when a strobe arrives while busy
//   o_chan_err     one-cycle pulse when i_channel_sel >= DAC_CHANNEL
//   o_sclk         SPI clock, idle low
//   o_mosi         SPI data
//   o_cs_n         one-hot active-low chip selects
//   o_word_idx     word being shifted, 0 when idle
//
// Optional build macro DC_SPI_READBACK_EN adds:
//   i_miso         SPI return data, sampled as SCLK rises
//   o_rdback       last word shifted in from i_miso
//   o_rdback_valid one-cycle pulse per word when o_rdback updates
module dc_dac_spi_writer #(
  parameter int unsigned FRAME_WORDS = 62,
  parameter int unsigned DAC_CHANNEL = 24,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_GAP      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [FRAME_WORDS*32-1:0] i_frame,
  input  logic [4:0]                i_channel_sel,
  input  logic                      i_frame_valid,
`ifdef DC_SPI_READBACK_EN
  input  logic                      i_miso,
  output logic [31:0]               o_rdback,
  output logic                      o_rdback_valid,
`endif
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_frame_drop,
  output logic                      o_chan_err,
  output logic                      o_sclk,
  output logic                      o_mosi,
  output logic [DAC_CHANNEL-1:0]    o_cs_n,
  output logic [5:0]                o_word_idx
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);
  localparam logic [5:0] LastIdx = 6'(FRAME_WORDS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StShiftLo = 3'd1;
  localparam logic [2:0] StShiftHi = 3'd2;
  localparam logic [2:0] StCsHold  = 3'd3;
  localparam logic [2:0] StGap     = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [4:0]             bit_q, bit_d;
  logic [5:0]             word_idx_q, word_idx_d;
  logic [4:0]             chan_q, chan_d;
  logic [31:0]            word_q, word_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic [DAC_CHANNEL-1:0] cs_n_q, cs_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;
  logic                   chan_err_q, chan_err_d;

  // Payload words only; the header is never stored.
  logic [31:0]            frame_q [1:FRAME_WORDS-1];
  logic                   frame_we;

  logic                   ch_ok;
  logic [DAC_CHANNEL-1:0] cs_acc;
  logic [DAC_CHANNEL-1:0] cs_cur;
  logic [4:0]             bit_dec;
  logic [5:0]             nxt_idx;
  logic [31:0]            nxt_word;
  logic [31:0]            unused_hdr;

`ifdef DC_SPI_READBACK_EN
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdback_q, rdback_d;
  logic        rdback_valid_q, rdback_valid_d;
`endif

  assign unused_hdr = i_frame[31:0];
  assign ch_ok      = ({27'd0, i_channel_sel} < DAC_CHANNEL);
  assign bit_dec    = bit_q - 5'd1;
  assign nxt_idx    = word_idx_q + 6'd1;
  assign nxt_word   = frame_q[nxt_idx];

  // Chip-select patterns for the incoming channel and the latched channel.
  always_comb begin
    cs_acc = '1;
    cs_cur = '1;
    for (int c = 0; c < DAC_CHANNEL; c++) begin
      cs_acc[c] = (5'(c) != i_channel_sel);
      cs_cur[c] = (5'(c) != chan_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    word_idx_d = word_idx_q;
    chan_d     = chan_q;
    word_d     = word_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    chan_err_d = 1'b0;
    frame_we   = 1'b0;
`ifdef DC_SPI_READBACK_EN
    rx_d           = rx_q;
    rdback_d       = rdback_q;
    rdback_valid_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_frame_valid) begin
          if (ch_ok) begin
            frame_we   = 1'b1;
            chan_d     = i_channel_sel;
            word_d     = i_frame[63:32];
            mosi_d     = i_frame[63];
            cs_n_d     = cs_acc;
            bit_d      = 5'd31;
            word_idx_d = 6'd1;
            div_d      = '0;
            sclk_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = StShiftLo;
          end else begin
            chan_err_d = 1'b1;
          end
        end
      end

      StShiftLo: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = StShiftHi;
`ifdef DC_SPI_READBACK_EN
          rx_d    = {rx_q[30:0], i_miso};
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StShiftHi: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_dec;
            mosi_d  = word_q[bit_dec];
            state_d = StShiftLo;
          end else begin
            state_d = StCsHold;
`ifdef DC_SPI_READBACK_EN
            rdback_d       = rx_q;
            rdback_valid_d = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StCsHold: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          cs_n_d  = '1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          gap_d = '0;
          if (word_idx_q < LastIdx) begin
            word_idx_d = nxt_idx;
            word_d     = nxt_word;
            mosi_d     = nxt_word[31];
            cs_n_d     = cs_cur;
            bit_d      = 5'd31;
            state_d    = StShiftLo;
          end else begin
            word_idx_d = 6'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (i_frame_valid && (state_q != StIdle)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      word_idx_q <= '0;
      chan_q     <= '0;
      word_q     <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      chan_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      word_idx_q <= word_idx_d;
      chan_q     <= chan_d;
      word_q     <= word_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      chan_err_q <= chan_err_d;
    end
  end

  // Frame buffer is data only and needs no reset.
  always_ff @(posedge i_clk) begin
    if (frame_we) begin
      for (int k = 1; k < FRAME_WORDS; k++) begin
        frame_q[k] <= i_frame[k*32 +: 32];
      end
    end
  end

`ifdef DC_SPI_READBACK_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_q           <= '0;
      rdback_q       <= '0;
      rdback_valid_q <= 1'b0;
    end else begin
      rx_q           <= rx_d;
      rdback_q       <= rdback_d;
      rdback_valid_q <= rdback_valid_d;
    end
  end

  assign o_rdback       = rdback_q;
  assign o_rdback_valid = rdback_valid_q;
`endif

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_frame_drop = drop_q;
  assign o_chan_err   = chan_err_q;
  assign o_sclk       = sclk_q;
  assign o_mosi       = mosi_q;
  assign o_cs_n       = cs_n_q;
  assign o_word_idx   = word_idx_q;

endmodule
